param_updown_counter: RTL

Parametrised up/down counter with programmable bounds, step size, wrap or saturate mode, synchronous load and clear, and a terminal-count pulse. It is the successor to the team's fixed 4-bit wrap counter and is used as a general timer/index generator in lab datapaths. With lo=0, hi=2^WIDTH-1, step=1 and sat_mode=0 it behaves exactly like the 4-bit wrap counter (enable, direction, load-on-enable).

---
 rtl/param_updown_counter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_updown_counter
//  Description : Parametrised up/down counter with programmable inclusive
//                bounds [lo, hi], programmable step, wrap or saturate at the
//                bounds, synchronous clear and load, and a registered
//                terminal-count pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     counter / bound width in bits (>= 2)
//    STEP_W    width of the step input (<= WIDTH)
//  Ports
//    clk        in   clock, all state updates on posedge
//    rst_n      in   asynchronous active-low reset (out=0, tc=0)
//    en         in   enable for load and count
//    dir        in   1 = up, 0 = down
//    load       in   load load_data when en=1
//    load_data  in   value to load (no range check)
//    clr        in   synchronous clear to lo, ignores en
//    lo, hi     in   inclusive bounds
//    step       in   count magnitude, 0 = hold
//    sat_mode   in   0 = wrap, 1 = saturate
//    out        out  registered count
//    tc         out  registered terminal-count pulse
//    at_hi      out  out == hi (combinational)
//    at_lo      out  out == lo (combinational)
//    cfg_err    out  lo > hi   (combinational)
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              dir,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              clr,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              at_hi,
    output logic              at_lo,
    output logic              cfg_err
);

    logic [WIDTH-1:0] r_out;
    logic             r_tc;

    // Arithmetic is carried one bit wider than the counter so that an
    // up-count overflowing the register is still seen as exceeding hi, and
    // lo+step cannot wrap around when testing the down boundary.
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_lo_plus_step;
    logic [WIDTH-1:0] w_diff;
    logic             w_up_evt;
    logic             w_dn_evt;
    logic             w_cfg_err;
    logic             w_count;
    logic [WIDTH-1:0] w_next_out;
    logic             w_next_tc;

    assign w_step_ext     = (WIDTH+1)'(step);
    assign w_sum          = {1'b0, r_out} + w_step_ext;
    assign w_lo_plus_step = {1'b0, lo} + w_step_ext;
    assign w_diff         = r_out - WIDTH'(step);

    assign w_up_evt  = (w_sum > {1'b0, hi});
    assign w_dn_evt  = ({1'b0, r_out} < w_lo_plus_step);
    assign w_cfg_err = (lo > hi);

    // A zero step is an explicit hold; it must not be treated as a boundary
    // event even when out is already outside [lo, hi].
    assign w_count = en && !load && !w_cfg_err && (step != '0);

    always_comb begin
        w_next_out = r_out;
        w_next_tc  = 1'b0;
        if (clr) begin
            w_next_out = lo;
        end else if (en && load) begin
            w_next_out = load_data;
        end else if (w_count) begin
            if (dir) begin
                if (w_up_evt) begin
                    w_next_out = sat_mode ? hi : lo;
                    w_next_tc  = 1'b1;
                end else begin
                    w_next_out = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_dn_evt) begin
                    w_next_out = sat_mode ? lo : hi;
                    w_next_tc  = 1'b1;
                end else begin
                    w_next_out = w_diff;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_tc  <= 1'b0;
        end else begin
            r_out <= w_next_out;
            r_tc  <= w_next_tc;
        end
    end

    assign out     = r_out;
    assign tc      = r_tc;
    assign at_hi   = (r_out == hi);
    assign at_lo   = (r_out == lo);
    assign cfg_err = w_cfg_err;

endmodule
`default_nettype wire
